// File: rtl/dco_pkg.sv
// Shared types and helpers for the DCO acquisition and tracking logic.
package dco_pkg;

  localparam int unsigned DCO_NCODE = 10;
  localparam int unsigned DCO_CNT_W = 12;
  localparam int unsigned DCO_IDX_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENABLE  = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_MEASURE = 3'd3,
    ST_EVAL    = 3'd4,
    ST_APPLY   = 3'd5,
    ST_HOLD    = 3'd6
  } dco_cal_state_t;

  function automatic logic [DCO_NCODE-1:0] onehot(input logic [DCO_IDX_W-1:0] idx);
    onehot = '0;
    for (int i = 0; i < int'(DCO_NCODE); i++) begin
      onehot[i] = (int'(idx) == i);
    end
  endfunction

  // Operands are zero-extended by the caller, so any counter width up to 32 fits.
  function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
    abs_diff = (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/dco_win_counter.sv
// Saturating event counter with synchronous clear and count enable.
module dco_win_counter
  import dco_pkg::*;
#(
  parameter int unsigned CNT_W = DCO_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_tick,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && i_tick && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/dco_cal_ctrl.sv
// DCO frequency acquisition: sweep every one-hot code, measure ticks per
// window, then apply and hold the code closest to the target count.
module dco_cal_ctrl
  import dco_pkg::*;
#(
  parameter int unsigned NCODE      = DCO_NCODE,
  parameter int unsigned CNT_W      = DCO_CNT_W,
  parameter int unsigned WIN_CYC    = 64,
  parameter int unsigned SETTLE_CYC = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CNT_W-1:0]     target_cnt,
  input  logic                 dco_tick,
  output logic [NCODE-1:0]     lambda,
  output logic                 e,
  output logic                 busy,
  output logic                 done,
  output logic [DCO_IDX_W-1:0] best_idx,
  output logic [CNT_W-1:0]     best_err,
  output logic [CNT_W-1:0]     meas_cnt
);

  localparam int unsigned CYC_MAX = (WIN_CYC > SETTLE_CYC) ? WIN_CYC : SETTLE_CYC;
  localparam int unsigned CYC_W   = $clog2(CYC_MAX + 1);

  dco_cal_state_t       r_state, w_state_nxt;
  logic [NCODE-1:0]     r_lambda, w_lambda_nxt;
  logic                 r_e, r_busy, r_done, w_done_nxt;
  logic [DCO_IDX_W-1:0] r_idx, w_idx_nxt, r_best_idx, w_best_idx_nxt;
  logic [CNT_W-1:0]     r_best_err, w_best_err_nxt, r_meas_cnt, w_meas_cnt_nxt;
  logic [CYC_W-1:0]     r_cyc, w_cyc_nxt;
  logic [CNT_W-1:0]     w_cnt, w_err;

  dco_win_counter #(.CNT_W(CNT_W)) u_win_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (r_state == ST_SETTLE),
    .i_en   (r_state == ST_MEASURE),
    .i_tick (dco_tick),
    .o_cnt  (w_cnt)
  );

  assign w_err = CNT_W'(abs_diff(32'(w_cnt), 32'(target_cnt)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_lambda   <= NCODE'(1);
      r_e        <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_idx      <= '0;
      r_best_idx <= '0;
      r_best_err <= '1;
      r_meas_cnt <= '0;
      r_cyc      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_lambda   <= w_lambda_nxt;
      r_e        <= (w_state_nxt != ST_IDLE);
      r_busy     <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_HOLD);
      r_done     <= w_done_nxt;
      r_idx      <= w_idx_nxt;
      r_best_idx <= w_best_idx_nxt;
      r_best_err <= w_best_err_nxt;
      r_meas_cnt <= w_meas_cnt_nxt;
      r_cyc      <= w_cyc_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_lambda_nxt   = r_lambda;
    w_done_nxt     = 1'b0;
    w_idx_nxt      = r_idx;
    w_best_idx_nxt = r_best_idx;
    w_best_err_nxt = r_best_err;
    w_meas_cnt_nxt = r_meas_cnt;
    w_cyc_nxt      = r_cyc;

    case (r_state)
      ST_IDLE: begin
        w_lambda_nxt = NCODE'(onehot('0));
        if (start) w_state_nxt = ST_ENABLE;
      end
      ST_ENABLE: begin
        w_idx_nxt      = '0;
        w_lambda_nxt   = NCODE'(onehot('0));
        w_best_err_nxt = '1;
        w_best_idx_nxt = '0;
        w_cyc_nxt      = '0;
        w_state_nxt    = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (r_cyc == CYC_W'(SETTLE_CYC - 1)) begin
          w_cyc_nxt   = '0;
          w_state_nxt = ST_MEASURE;
        end else begin
          w_cyc_nxt = r_cyc + CYC_W'(1);
        end
      end
      ST_MEASURE: begin
        if (r_cyc == CYC_W'(WIN_CYC - 1)) begin
          w_cyc_nxt   = '0;
          w_state_nxt = ST_EVAL;
        end else begin
          w_cyc_nxt = r_cyc + CYC_W'(1);
        end
      end
      ST_EVAL: begin
        w_meas_cnt_nxt = w_cnt;
        // Strict compare so that ties keep the earlier (lower) code.
        if (w_err < r_best_err) begin
          w_best_err_nxt = w_err;
          w_best_idx_nxt = r_idx;
        end
        if ((w_err == '0) || (r_idx == DCO_IDX_W'(NCODE - 1))) begin
          w_state_nxt = ST_APPLY;
        end else begin
          w_idx_nxt    = r_idx + DCO_IDX_W'(1);
          w_lambda_nxt = NCODE'(onehot(r_idx + DCO_IDX_W'(1)));
          w_cyc_nxt    = '0;
          w_state_nxt  = ST_SETTLE;
        end
      end
      ST_APPLY: begin
        w_lambda_nxt = NCODE'(onehot(r_best_idx));
        w_done_nxt   = 1'b1;
        w_state_nxt  = ST_HOLD;
      end
      ST_HOLD: begin
        if (start) w_state_nxt = ST_ENABLE;
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_lambda_nxt = NCODE'(onehot('0));
      end
    endcase

    // Abort overrides everything; best_* results are retained.
    if (abort) begin
      w_state_nxt  = ST_IDLE;
      w_lambda_nxt = NCODE'(onehot('0));
      w_done_nxt   = 1'b0;
      w_idx_nxt    = '0;
      w_cyc_nxt    = '0;
    end
  end

  assign lambda   = r_lambda;
  assign e        = r_e;
  assign busy     = r_busy;
  assign done     = r_done;
  assign best_idx = r_best_idx;
  assign best_err = r_best_err;
  assign meas_cnt = r_meas_cnt;

endmodule
